// File: rtl/cpu_top.sv
// cpu_top: 32-bit, 5-stage in-order MIPS-subset pipeline (IF, ID, EX, MEM, WB).
// EX-stage forwarding, one-cycle load-use stall, and beq resolved in EX
// (a taken branch costs 2 cycles). The register file instance is RF.
// Handshake note: the pipeline has no valid/ready interfaces. A stage
// "advances" unless the load-use stall holds PC and IF/ID. Bubbles and
// flushes are all-zero records, which have no architectural effect.

module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] regs [0:31];

  // Storage: cleared on reset; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs[wa_i] <= wd_i;
    end
  end

  // Read ports: r0 reads zero; a read of the register being written this cycle sees the new value.
  always_comb begin
    rd1_o = regs[ra1_i];
    rd2_o = regs[ra2_i];
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == 5'd0) rd1_o = '0;
    if (ra2_i == 5'd0) rd2_o = '0;
  end
endmodule

module cpu_top (
  input logic clk,
  input logic rst
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] store;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dst;
    logic [31:0] result;
  } mem_wb_t;

  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  id_ex_t      idex_q, idex_d;
  ex_mem_t     exmem_q, exmem_d;
  mem_wb_t     memwb_q, memwb_d;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];

  id_ex_t      id_dec;
  logic [31:0] rf_rd1, rf_rd2;
  logic        load_use;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] dmem_rdata;
  logic        unused_shamt;

  assign unused_shamt = ^ifid_q.instr[10:6];

  cpu_regfile RF (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (ifid_q.instr[25:21]),
    .ra2_i (ifid_q.instr[20:16]),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (memwb_q.reg_write),
    .wa_i  (memwb_q.dst),
    .wd_i  (memwb_q.result)
  );

  // Instruction ROM: default program is (re)established by reset, never written by the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) imem[i] <= '0;
      imem[0] <= 32'h2001_0005;
      imem[1] <= 32'h0021_1020;
    end
  end

  // Data memory: synchronous write from MEM, no reset.
  always_ff @(posedge clk) begin
    if (exmem_q.mem_write) dmem[exmem_q.alu[7:2]] <= exmem_q.store;
  end

  // ID decode: unsupported encodings leave every control bit at zero (NOP).
  always_comb begin
    id_dec     = '0;
    id_dec.rs  = ifid_q.instr[25:21];
    id_dec.rt  = ifid_q.instr[20:16];
    id_dec.rd1 = rf_rd1;
    id_dec.rd2 = rf_rd2;
    id_dec.imm = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    id_dec.pc4 = ifid_q.pc4;
    case (ifid_q.instr[31:26])
      6'h00: begin
        id_dec.dst = ifid_q.instr[15:11];
        case (ifid_q.instr[5:0])
          6'h20: begin id_dec.reg_write = 1'b1; id_dec.alu_op = ALU_ADD; end
          6'h22: begin id_dec.reg_write = 1'b1; id_dec.alu_op = ALU_SUB; end
          6'h24: begin id_dec.reg_write = 1'b1; id_dec.alu_op = ALU_AND; end
          6'h25: begin id_dec.reg_write = 1'b1; id_dec.alu_op = ALU_OR;  end
          6'h2A: begin id_dec.reg_write = 1'b1; id_dec.alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      6'h08: begin
        id_dec.reg_write = 1'b1;
        id_dec.alu_src   = 1'b1;
        id_dec.dst       = ifid_q.instr[20:16];
      end
      6'h23: begin
        id_dec.reg_write = 1'b1;
        id_dec.mem_read  = 1'b1;
        id_dec.alu_src   = 1'b1;
        id_dec.dst       = ifid_q.instr[20:16];
      end
      6'h2B: begin
        id_dec.mem_write = 1'b1;
        id_dec.alu_src   = 1'b1;
      end
      6'h04: id_dec.branch = 1'b1;
      default: ;
    endcase
  end

  // Load-use detection: a load in EX whose target feeds the instruction in ID.
  assign load_use = idex_q.mem_read &&
                    ((idex_q.rt == id_dec.rs) || (idex_q.rt == id_dec.rt));

  // EX: operand forwarding (EX/MEM first, then MEM/WB), ALU and branch resolution.
  always_comb begin
    fwd_a = idex_q.rd1;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rs))
      fwd_a = exmem_q.alu;
    else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rs))
      fwd_a = memwb_q.result;
    fwd_b = idex_q.rd2;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rt))
      fwd_b = exmem_q.alu;
    else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rt))
      fwd_b = memwb_q.result;
    alu_b = idex_q.alu_src ? idex_q.imm : fwd_b;
    case (idex_q.alu_op)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
      default: alu_res = fwd_a + alu_b;
    endcase
    branch_taken  = idex_q.branch && (fwd_a == fwd_b);
    branch_target = idex_q.pc4 + (idex_q.imm << 2);
  end

  assign dmem_rdata = dmem[exmem_q.alu[7:2]];

  // Next state of PC and pipeline registers; a taken branch overrides a load-use stall.
  always_comb begin
    pc_d          = pc_q + 32'd4;
    ifid_d.instr  = imem[pc_q[7:2]];
    ifid_d.pc4    = pc_q + 32'd4;
    idex_d        = id_dec;
    exmem_d.reg_write = idex_q.reg_write;
    exmem_d.mem_read  = idex_q.mem_read;
    exmem_d.mem_write = idex_q.mem_write;
    exmem_d.dst       = idex_q.dst;
    exmem_d.alu       = alu_res;
    exmem_d.store     = fwd_b;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.dst       = exmem_q.dst;
    memwb_d.result    = exmem_q.mem_read ? dmem_rdata : exmem_q.alu;
    if (branch_taken) begin
      pc_d   = branch_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (load_use) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  // State registers: reset aborts everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: default program, directed vector table, mid-run reset,
// and random programs checked against an instruction-level reference model.

module tb_cpu_top;
  logic clk;
  logic rst;

  cpu_top dut (
    .clk (clk),
    .rst (rst)
  );

  // Clock and initial reset level
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_prog [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];
  int          prog_len;

  typedef struct {
    logic [7:0][31:0] prog;
    int               len;
    int               cycles;
    logic [31:0]      exp_pc;
    int               nchk;
    logic [3:0][4:0]  chk_reg;
    logic [3:0][31:0] chk_val;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Driver: reset for two cycles, preload data memory, optionally load a program after release.
  task automatic do_reset(input bit load_prog);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) dut.dmem[i] = m_mem[i];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    if (load_prog) for (int i = 0; i < 64; i++) dut.imem[i] = m_prog[i];
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: executes the program one instruction at a time, architecturally.
  task automatic model_run();
    logic [31:0] pc, ins, a, b, imm, addr;
    int steps;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    pc = '0;
    steps = 0;
    while ((pc < 32'(prog_len * 4)) && (steps < 500)) begin
      ins  = m_prog[pc[7:2]];
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      imm  = {{16{ins[15]}}, ins[15:0]};
      addr = a + imm;
      pc   = pc + 32'd4;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: m_regs[ins[15:11]] = a + b;
          6'h22: m_regs[ins[15:11]] = a - b;
          6'h24: m_regs[ins[15:11]] = a & b;
          6'h25: m_regs[ins[15:11]] = a | b;
          6'h2A: m_regs[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: m_regs[ins[20:16]] = addr;
        6'h23: m_regs[ins[20:16]] = m_mem[addr[7:2]];
        6'h2B: m_mem[addr[7:2]] = b;
        6'h04: if (a == b) pc = pc + (imm << 2);
        default: ;
      endcase
      m_regs[0] = '0;
      steps++;
    end
  endtask

  // Scoreboard: queue the model's registers and memory, then compare against the DUT.
  task automatic score_state(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) exp_q.push_back(m_regs[i]);
    for (int i = 0; i < 64; i++) exp_q.push_back(m_mem[i]);
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_r%0d", tag, i), dut.RF.regs[i], e);
    end
    for (int i = 0; i < 64; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_mem%0d", tag, i), dut.dmem[i], e);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    logic [31:0] w;
    a   = 5'($urandom_range(0, 7));
    b   = 5'($urandom_range(0, 7));
    c   = 5'($urandom_range(0, 7));
    imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20)) - 16'd8;
    case ($urandom_range(0, 12))
      0:  w = enc_r(c, a, b, 6'h20);
      1:  w = enc_r(c, a, b, 6'h22);
      2:  w = enc_r(c, a, b, 6'h24);
      3:  w = enc_r(c, a, b, 6'h25);
      4:  w = enc_r(c, a, b, 6'h2A);
      5, 6: w = enc_i(6'h08, a, b, imm);
      7:  w = enc_i(6'h23, a, b, imm);
      8:  w = enc_i(6'h2B, a, b, imm);
      9:  w = enc_i(6'h04, {3'd0, a[1:0]}, {3'd0, b[1:0]}, 16'($urandom_range(0, 3)));
      10: w = 32'd0;
      11: w = enc_r(c, a, b, 6'h21);
      default: begin
        w = $urandom;
        if (w[31:26] inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04}) w[31:26] = 6'h3F;
      end
    endcase
    return w;
  endfunction

  initial begin
    // Default program straight out of reset
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = $urandom;
      dut.dmem[i] = m_mem[i];
    end
    #20;
    rst = 1'b1;
    run_cycles(20);
    chk("dflt_pc", dut.pc_q, 32'd80);
    chk("dflt_r1", dut.RF.regs[1], 32'd5);
    chk("dflt_r2", dut.RF.regs[2], 32'd10);
    for (int i = 0; i < 32; i++)
      if (i != 1 && i != 2) chk($sformatf("dflt_zero_r%0d", i), dut.RF.regs[i], 32'd0);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      vecs[v].prog = '0;
      vecs[v].chk_reg = '0;
      vecs[v].chk_val = '0;
    end
    vecs[0].prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    vecs[0].prog[1] = enc_r(5'd2, 5'd1, 5'd1, 6'h20);
    vecs[0].prog[2] = enc_r(5'd3, 5'd2, 5'd1, 6'h22);
    vecs[0].len = 3; vecs[0].cycles = 10; vecs[0].exp_pc = 32'd40; vecs[0].nchk = 3;
    vecs[0].chk_reg[0] = 5'd1; vecs[0].chk_val[0] = 32'd3;
    vecs[0].chk_reg[1] = 5'd2; vecs[0].chk_val[1] = 32'd6;
    vecs[0].chk_reg[2] = 5'd3; vecs[0].chk_val[2] = 32'd3;

    vecs[1].prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    vecs[1].prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd0);
    vecs[1].prog[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
    vecs[1].prog[3] = enc_r(5'd5, 5'd4, 5'd4, 6'h20);
    vecs[1].len = 4; vecs[1].cycles = 12; vecs[1].exp_pc = 32'd44; vecs[1].nchk = 3;
    vecs[1].chk_reg[0] = 5'd1; vecs[1].chk_val[0] = 32'd7;
    vecs[1].chk_reg[1] = 5'd4; vecs[1].chk_val[1] = 32'd7;
    vecs[1].chk_reg[2] = 5'd5; vecs[1].chk_val[2] = 32'd14;

    vecs[2].prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    vecs[2].prog[1] = enc_i(6'h04, 5'd1, 5'd1, 16'd1);
    vecs[2].prog[2] = enc_i(6'h08, 5'd0, 5'd6, 16'd9);
    vecs[2].prog[3] = enc_i(6'h08, 5'd0, 5'd7, 16'd4);
    vecs[2].len = 4; vecs[2].cycles = 12; vecs[2].exp_pc = 32'd44; vecs[2].nchk = 3;
    vecs[2].chk_reg[0] = 5'd1; vecs[2].chk_val[0] = 32'd1;
    vecs[2].chk_reg[1] = 5'd6; vecs[2].chk_val[1] = 32'd0;
    vecs[2].chk_reg[2] = 5'd7; vecs[2].chk_val[2] = 32'd4;

    vecs[3].prog[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
    vecs[3].prog[1] = enc_r(5'd8, 5'd0, 5'd0, 6'h20);
    vecs[3].len = 2; vecs[3].cycles = 10; vecs[3].exp_pc = 32'd40; vecs[3].nchk = 2;
    vecs[3].chk_reg[0] = 5'd0; vecs[3].chk_val[0] = 32'd0;
    vecs[3].chk_reg[1] = 5'd8; vecs[3].chk_val[1] = 32'd0;

    vecs[4].prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
    vecs[4].prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    vecs[4].prog[2] = enc_r(5'd3, 5'd1, 5'd2, 6'h2A);
    vecs[4].prog[3] = enc_r(5'd4, 5'd2, 5'd1, 6'h2A);
    vecs[4].prog[4] = enc_r(5'd5, 5'd1, 5'd2, 6'h24);
    vecs[4].prog[5] = enc_r(5'd6, 5'd1, 5'd2, 6'h25);
    vecs[4].len = 6; vecs[4].cycles = 14; vecs[4].exp_pc = 32'd56; vecs[4].nchk = 4;
    vecs[4].chk_reg[0] = 5'd3; vecs[4].chk_val[0] = 32'd1;
    vecs[4].chk_reg[1] = 5'd4; vecs[4].chk_val[1] = 32'd0;
    vecs[4].chk_reg[2] = 5'd5; vecs[4].chk_val[2] = 32'd5;
    vecs[4].chk_reg[3] = 5'd6; vecs[4].chk_val[3] = 32'hFFFF_FFFD;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 64; i++) begin
        m_prog[i] = (i < vecs[v].len) ? vecs[v].prog[i] : 32'd0;
        m_mem[i]  = $urandom;
      end
      prog_len = vecs[v].len;
      do_reset(1'b1);
      model_run();
      run_cycles(vecs[v].cycles);
      chk($sformatf("vec%0d_pc", v), dut.pc_q, vecs[v].exp_pc);
      for (int k = 0; k < vecs[v].nchk; k++)
        chk($sformatf("vec%0d_spec_r%0d", v, vecs[v].chk_reg[k]),
            dut.RF.regs[vecs[v].chk_reg[k]], vecs[v].chk_val[k]);
      score_state($sformatf("vec%0d", v));
    end

    // Writeback latency and mid-run reset on the default program
    do_reset(1'b0);
    run_cycles(4);
    chk("lat_r1_before", dut.RF.regs[1], 32'd0);
    run_cycles(1);
    chk("lat_r1_at5", dut.RF.regs[1], 32'd5);
    chk("lat_r2_at5", dut.RF.regs[2], 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_pc", dut.pc_q, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("midrst_r%0d", i), dut.RF.regs[i], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_cycles(20);
    chk("rerun_pc", dut.pc_q, 32'd80);
    chk("rerun_r1", dut.RF.regs[1], 32'd5);
    chk("rerun_r2", dut.RF.regs[2], 32'd10);

    // Random programs against the reference model
    for (int t = 0; t < 25; t++) begin
      prog_len = 12;
      for (int i = 0; i < 64; i++) begin
        m_prog[i] = (i < prog_len) ? rand_instr() : 32'd0;
        m_mem[i]  = $urandom;
      end
      do_reset(1'b1);
      model_run();
      run_cycles(45);
      score_state($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; 0 = in reset.
REQ-003 No other ports; all observation is hierarchical.
REQ-004 Register file instance named RF, holding storage array regs[0:31], each 32 bits, readable hierarchically as RF.regs[n].

Function
REQ-005 The design SHALL be a 32-bit, 5-stage in-order MIPS pipeline: IF, ID, EX, MEM, WB, with pipeline registers IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-006 Supported instructions:
- R-type (opcode 0x00): add (funct 0x20), sub (0x22), and (0x24), or (0x25), slt (0x2A).
- I-type: addi (0x08), lw (0x23), sw (0x2B), beq (0x04).
- All other encodings, including 0x00000000, SHALL execute as NOP with no architectural effect.
REQ-007 Instruction memory: 64 x 32-bit words, read-only, combinational, indexed by PC[7:2].
- Default contents: word0 = addi r1,r0,5 (0x20010005); word1 = add r2,r1,r1 (0x00211020); all other words 0 (NOP).
REQ-008 Data memory: 64 x 32-bit words, indexed by address[7:2], combinational read, synchronous write in MEM.
REQ-009 PC increments by 4 each cycle unless stalled or a branch is taken; PC wraps modulo 2^32.
REQ-010 Register file timing:
- 2 combinational read ports, 1 write port, write on rising edge in WB.
- Writes to r0 ignored; r0 always reads 0.
- Write-before-read bypass: an ID read of the register being written in WB returns the new value.
REQ-011 Arithmetic:
- add/addi/sub wrap modulo 2^32; overflow ignored, no exceptions.
- addi immediate and lw/sw offset are sign-extended.
- slt is a signed compare, result 1 or 0.
REQ-012 Forwarding unit in EX for each ALU source operand, highest priority first:
- EX/MEM result, if EX/MEM writes a nonzero rd matching the source;
- else MEM/WB result, under the same condition;
- else the register-file value.
REQ-013 Dependent back-to-back ALU instructions SHALL execute with no stall cycle.
REQ-014 Load-use hazard:
- Trigger: ID/EX holds lw and its rt equals rs or rt of the instruction in ID.
- Response: stall PC and IF/ID for exactly 1 cycle and insert a bubble into ID/EX.
- The loaded value then forwards from MEM/WB.
REQ-015 beq:
- Resolved in EX using forwarded operands; target = PC+4 + (sign-extended imm << 2).
- Taken: flush IF/ID and ID/EX (convert to NOP) and load the target.
- Penalty: 2 cycles taken, 0 not taken.
REQ-016 Simultaneous load-use stall and taken branch in EX: the branch flush takes priority.
REQ-017 Latency: an ALU result is written to RF.regs on the rising edge ending its WB stage, 5 cycles after fetch.

Reset
REQ-018 While rst = 0 (asynchronous):
- PC = 0.
- All pipeline registers cleared to NOP: control signals 0, no register write, no memory write.
- RF.regs all 0.
REQ-019 Data memory contents are not reset.
REQ-020 Fetch from address 0 begins on the first rising edge after rst rises.
REQ-021 Reset asserted mid-execution SHALL abort all in-flight instructions immediately; no partial writes complete.

Verification
REQ-022 Default program, rst low 20 ns then high, 10 ns clock; after 20 cycles -> RF.regs[1] = 5, RF.regs[2] = 10, all others 0.
REQ-023 Forwarding chain addi r1,r0,3; add r2,r1,r1; sub r3,r2,r1 -> r2 = 6, r3 = 3; PC advances every cycle with no stall.
REQ-024 Load-use: addi r1,r0,7; sw r1,0(r0); lw r4,0(r0); add r5,r4,r4 -> r5 = 14; exactly one bubble inserted.
REQ-025 Branch: addi r1,r0,1; beq r1,r1,+1; addi r6,r0,9; addi r7,r0,4 -> r6 = 0, r7 = 4; the two fetched-after-branch instructions are flushed.
REQ-026 r0 protection: addi r0,r0,5 then add r8,r0,r0 -> RF.regs[0] = 0, r8 = 0.
REQ-027 Mid-run reset: drive rst low for 1 cycle during the default program -> all regs 0, PC = 0; after release the program reruns to r2 = 10.
